// File: rtl/param_counter.sv
// rtl/param_counter.sv - parametrised up/down/bounce counter with prescaler, load and terminal-count pulse
module param_counter #(
    parameter int          WIDTH     = 4,
    parameter int unsigned MAX_VAL   = 15,
    parameter int          PRESCALE  = 1,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] po_cnt,
    output logic             po_tc,
    output logic             po_dir,
    output logic             po_tick
);

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    // A 1-bit prescaler is kept even for PRESCALE=1; it simply never leaves 0.
    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W    = WIDTH'(RESET_VAL);

    logic [PW-1:0]    r_pre;
    logic [WIDTH-1:0] r_cnt;
    logic             r_dir;
    logic             r_tc;
    logic             r_tick;

    logic             w_step;
    mode_e            w_mode;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_next_cnt;
    logic             w_next_dir;
    logic             w_next_tc;
    logic             w_next_tick;

    assign w_step         = en && (r_pre == PRE_LAST);
    assign w_mode         = mode_e'(mode);
    assign w_load_clamped = (load_val > MAX_W) ? MAX_W : load_val;

    // Prescaler: advances on enabled cycles, wraps on the step, cleared by reset or load.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_pre <= '0;
        end else if (en) begin
            r_pre <= w_step ? '0 : r_pre + 1'b1;
        end
    end

    // Next count/direction/pulses: load beats step; hold mode only ticks.
    always_comb begin
        w_next_cnt  = r_cnt;
        w_next_dir  = r_dir;
        w_next_tc   = 1'b0;
        w_next_tick = 1'b0;
        if (load) begin
            w_next_cnt = w_load_clamped;
        end else begin
            case (w_mode)
                MODE_UP: begin
                    w_next_dir = 1'b1;
                    if (w_step) begin
                        w_next_tick = 1'b1;
                        if (r_cnt == MAX_W) begin
                            w_next_cnt = '0;
                            w_next_tc  = 1'b1;
                        end else begin
                            w_next_cnt = r_cnt + 1'b1;
                        end
                    end
                end
                MODE_DOWN: begin
                    w_next_dir = 1'b0;
                    if (w_step) begin
                        w_next_tick = 1'b1;
                        if (r_cnt == '0) begin
                            w_next_cnt = MAX_W;
                            w_next_tc  = 1'b1;
                        end else begin
                            w_next_cnt = r_cnt - 1'b1;
                        end
                    end
                end
                MODE_BOUNCE: begin
                    if (w_step) begin
                        w_next_tick = 1'b1;
                        if (MAX_W == '0) begin
                            // Degenerate range: every step is a turnaround but there is nowhere to go.
                            w_next_tc = 1'b1;
                        end else if (r_dir && (r_cnt == MAX_W)) begin
                            w_next_cnt = MAX_W - 1'b1;
                            w_next_dir = 1'b0;
                            w_next_tc  = 1'b1;
                        end else if (!r_dir && (r_cnt == '0)) begin
                            w_next_cnt = {{(WIDTH-1){1'b0}}, 1'b1};
                            w_next_dir = 1'b1;
                            w_next_tc  = 1'b1;
                        end else if (r_dir) begin
                            w_next_cnt = r_cnt + 1'b1;
                        end else begin
                            w_next_cnt = r_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    w_next_tick = w_step;
                end
            endcase
        end
    end

    // Output registers so tick/tc line up with the cycle the new count appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= RST_W;
            r_dir  <= 1'b1;
            r_tc   <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_next_cnt;
            r_dir  <= w_next_dir;
            r_tc   <= w_next_tc;
            r_tick <= w_next_tick;
        end
    end

    assign po_cnt  = r_cnt;
    assign po_dir  = r_dir;
    assign po_tc   = r_tc;
    assign po_tick = r_tick;

endmodule

// File: tb/tb_param_counter.sv
// tb/tb_param_counter.sv - directed self-checking bench for param_counter
module tb_param_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors;
    int checks;

    // A: defaults (WIDTH=4, MAX_VAL=15, PRESCALE=1)
    logic       a_rst, a_en, a_load, a_tc, a_dir, a_tick;
    logic [1:0] a_mode;
    logic [3:0] a_load_val, a_cnt;
    // B: MAX_VAL=9, PRESCALE=3
    logic       b_rst, b_en, b_load, b_tc, b_dir, b_tick;
    logic [1:0] b_mode;
    logic [3:0] b_load_val, b_cnt;
    // C: MAX_VAL=9, PRESCALE=1, RESET_VAL=2
    logic       c_rst, c_en, c_load, c_tc, c_dir, c_tick;
    logic [1:0] c_mode;
    logic [3:0] c_load_val, c_cnt;
    // D: WIDTH=1, MAX_VAL=1 and E: WIDTH=2, MAX_VAL=0 share stimulus
    logic       s_rst, s_en, s_load;
    logic [1:0] s_mode;
    logic       d_load_val, d_cnt, d_tc, d_dir, d_tick;
    logic [1:0] e_load_val, e_cnt;
    logic       e_tc, e_dir, e_tick;

    param_counter #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(1), .RESET_VAL(0)) u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode), .load(a_load), .load_val(a_load_val),
        .po_cnt(a_cnt), .po_tc(a_tc), .po_dir(a_dir), .po_tick(a_tick));
    param_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3), .RESET_VAL(0)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode), .load(b_load), .load_val(b_load_val),
        .po_cnt(b_cnt), .po_tc(b_tc), .po_dir(b_dir), .po_tick(b_tick));
    param_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .RESET_VAL(2)) u_c (
        .clk(clk), .rst(c_rst), .en(c_en), .mode(c_mode), .load(c_load), .load_val(c_load_val),
        .po_cnt(c_cnt), .po_tc(c_tc), .po_dir(c_dir), .po_tick(c_tick));
    param_counter #(.WIDTH(1), .MAX_VAL(1), .PRESCALE(1), .RESET_VAL(0)) u_d (
        .clk(clk), .rst(s_rst), .en(s_en), .mode(s_mode), .load(s_load), .load_val(d_load_val),
        .po_cnt(d_cnt), .po_tc(d_tc), .po_dir(d_dir), .po_tick(d_tick));
    param_counter #(.WIDTH(2), .MAX_VAL(0), .PRESCALE(1), .RESET_VAL(0)) u_e (
        .clk(clk), .rst(s_rst), .en(s_en), .mode(s_mode), .load(s_load), .load_val(e_load_val),
        .po_cnt(e_cnt), .po_tc(e_tc), .po_dir(e_dir), .po_tick(e_tick));

    task automatic test_reset();
        a_rst = 1; a_en = 0; a_mode = 2'b00; a_load = 0; a_load_val = 0;
        b_rst = 1; b_en = 0; b_mode = 2'b00; b_load = 0; b_load_val = 0;
        c_rst = 1; c_en = 0; c_mode = 2'b00; c_load = 0; c_load_val = 0;
        s_rst = 1; s_en = 0; s_mode = 2'b00; s_load = 0; d_load_val = 0; e_load_val = 0;
        repeat (5) @(negedge clk);
        checks++; if (a_cnt !== 4'd0) begin errors++; $display("FAIL reset_a_cnt got=%0d exp=0", a_cnt); end
        checks++; if (a_dir !== 1'b1) begin errors++; $display("FAIL reset_a_dir got=%b exp=1", a_dir); end
        checks++; if (a_tc !== 1'b0) begin errors++; $display("FAIL reset_a_tc got=%b exp=0", a_tc); end
        checks++; if (a_tick !== 1'b0) begin errors++; $display("FAIL reset_a_tick got=%b exp=0", a_tick); end
        checks++; if (b_cnt !== 4'd0) begin errors++; $display("FAIL reset_b_cnt got=%0d exp=0", b_cnt); end
        checks++; if (c_cnt !== 4'd2) begin errors++; $display("FAIL reset_c_cnt got=%0d exp=2", c_cnt); end
        checks++; if (c_dir !== 1'b1) begin errors++; $display("FAIL reset_c_dir got=%b exp=1", c_dir); end
        checks++; if (d_cnt !== 1'b0) begin errors++; $display("FAIL reset_d_cnt got=%0d exp=0", d_cnt); end
        checks++; if (e_cnt !== 2'd0) begin errors++; $display("FAIL reset_e_cnt got=%0d exp=0", e_cnt); end
    endtask

    task automatic test_up_wrap();
        a_rst = 0; a_en = 1; a_mode = 2'b00;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            checks++; if (a_cnt !== 4'(i % 16)) begin errors++; $display("FAIL up_cnt i=%0d got=%0d exp=%0d", i, a_cnt, i % 16); end
            checks++; if (a_tick !== 1'b1) begin errors++; $display("FAIL up_tick i=%0d got=%b exp=1", i, a_tick); end
            checks++; if (a_tc !== (i == 16)) begin errors++; $display("FAIL up_tc i=%0d got=%b exp=%b", i, a_tc, (i == 16)); end
            checks++; if (a_dir !== 1'b1) begin errors++; $display("FAIL up_dir i=%0d got=%b exp=1", i, a_dir); end
        end
        a_en = 0;
    endtask

    task automatic test_prescale();
        logic       en_seq [7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] cnt_seq [7] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
        logic       tk_seq [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        b_rst = 0; b_en = 1; b_mode = 2'b00;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            checks++; if (b_cnt !== 4'((k / 3) % 10)) begin errors++; $display("FAIL pre_cnt k=%0d got=%0d exp=%0d", k, b_cnt, (k / 3) % 10); end
            checks++; if (b_tick !== (k % 3 == 0)) begin errors++; $display("FAIL pre_tick k=%0d got=%b exp=%b", k, b_tick, (k % 3 == 0)); end
            checks++; if (b_tc !== (k == 30)) begin errors++; $display("FAIL pre_tc k=%0d got=%b exp=%b", k, b_tc, (k == 30)); end
        end
        for (int j = 0; j < 7; j++) begin
            b_en = en_seq[j];
            @(negedge clk);
            checks++; if (b_cnt !== cnt_seq[j]) begin errors++; $display("FAIL pause_cnt j=%0d got=%0d exp=%0d", j, b_cnt, cnt_seq[j]); end
            checks++; if (b_tick !== tk_seq[j]) begin errors++; $display("FAIL pause_tick j=%0d got=%b exp=%b", j, b_tick, tk_seq[j]); end
        end
    endtask

    task automatic test_load();
        b_en = 1;
        @(negedge clk);
        b_en = 0; b_load = 1; b_load_val = 4'd13;
        @(negedge clk);
        checks++; if (b_cnt !== 4'd9) begin errors++; $display("FAIL load_clamp got=%0d exp=9", b_cnt); end
        checks++; if (b_tick !== 1'b0) begin errors++; $display("FAIL load_tick got=%b exp=0", b_tick); end
        b_load = 0; b_en = 1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++; if (b_cnt !== ((k == 3) ? 4'd0 : 4'd9)) begin errors++; $display("FAIL load_pre_cnt k=%0d got=%0d exp=%0d", k, b_cnt, (k == 3) ? 0 : 9); end
            checks++; if (b_tc !== (k == 3)) begin errors++; $display("FAIL load_pre_tc k=%0d got=%b exp=%b", k, b_tc, (k == 3)); end
        end
        repeat (2) @(negedge clk);
        b_load = 1; b_load_val = 4'd4;
        @(negedge clk);
        checks++; if (b_cnt !== 4'd4) begin errors++; $display("FAIL load_vs_step_cnt got=%0d exp=4", b_cnt); end
        checks++; if (b_tick !== 1'b0) begin errors++; $display("FAIL load_vs_step_tick got=%b exp=0", b_tick); end
        checks++; if (b_tc !== 1'b0) begin errors++; $display("FAIL load_vs_step_tc got=%b exp=0", b_tc); end
        b_load = 0; b_en = 0;
    endtask

    task automatic test_down_hold();
        logic [3:0] cnt_seq [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
        logic       tc_seq [4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        c_rst = 0; c_en = 1; c_mode = 2'b01;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++; if (c_cnt !== cnt_seq[j]) begin errors++; $display("FAIL down_cnt j=%0d got=%0d exp=%0d", j, c_cnt, cnt_seq[j]); end
            checks++; if (c_tc !== tc_seq[j]) begin errors++; $display("FAIL down_tc j=%0d got=%b exp=%b", j, c_tc, tc_seq[j]); end
            checks++; if (c_dir !== 1'b0) begin errors++; $display("FAIL down_dir j=%0d got=%b exp=0", j, c_dir); end
        end
        c_mode = 2'b11;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++; if (c_cnt !== 4'd8) begin errors++; $display("FAIL hold_cnt j=%0d got=%0d exp=8", j, c_cnt); end
            checks++; if (c_tick !== 1'b1) begin errors++; $display("FAIL hold_tick j=%0d got=%b exp=1", j, c_tick); end
            checks++; if (c_tc !== 1'b0) begin errors++; $display("FAIL hold_tc j=%0d got=%b exp=0", j, c_tc); end
        end
    endtask

    task automatic test_bounce();
        int p;
        int e;
        c_en = 0; c_load = 1; c_load_val = 4'd0;
        @(negedge clk);
        checks++; if (c_cnt !== 4'd0) begin errors++; $display("FAIL bload_cnt got=%0d exp=0", c_cnt); end
        checks++; if (c_dir !== 1'b0) begin errors++; $display("FAIL bload_dir got=%b exp=0", c_dir); end
        c_load = 0; c_mode = 2'b00;
        @(negedge clk);
        checks++; if (c_dir !== 1'b1) begin errors++; $display("FAIL mode_dir got=%b exp=1", c_dir); end
        checks++; if (c_tick !== 1'b0) begin errors++; $display("FAIL mode_dir_tick got=%b exp=0", c_tick); end
        c_mode = 2'b10; c_en = 1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            p = k % 18;
            e = (p <= 9) ? p : 18 - p;
            checks++; if (c_cnt !== 4'(e)) begin errors++; $display("FAIL bounce_cnt k=%0d got=%0d exp=%0d", k, c_cnt, e); end
            checks++; if (c_dir !== (p >= 1 && p <= 9)) begin errors++; $display("FAIL bounce_dir k=%0d got=%b exp=%b", k, c_dir, (p >= 1 && p <= 9)); end
            checks++; if (c_tc !== ((p == 10) || (p == 1 && k > 18))) begin errors++; $display("FAIL bounce_tc k=%0d got=%b exp=%b", k, c_tc, ((p == 10) || (p == 1 && k > 18))); end
        end
    endtask

    task automatic test_reset_mid();
        c_rst = 1;
        @(negedge clk);
        checks++; if (c_cnt !== 4'd2) begin errors++; $display("FAIL rmid_cnt got=%0d exp=2", c_cnt); end
        checks++; if (c_dir !== 1'b1) begin errors++; $display("FAIL rmid_dir got=%b exp=1", c_dir); end
        checks++; if (c_tc !== 1'b0) begin errors++; $display("FAIL rmid_tc got=%b exp=0", c_tc); end
        checks++; if (c_tick !== 1'b0) begin errors++; $display("FAIL rmid_tick got=%b exp=0", c_tick); end
        c_rst = 0;
        @(negedge clk);
        checks++; if (c_cnt !== 4'd3) begin errors++; $display("FAIL rmid_resume_cnt got=%0d exp=3", c_cnt); end
        checks++; if (c_tick !== 1'b1) begin errors++; $display("FAIL rmid_resume_tick got=%b exp=1", c_tick); end
        c_en = 0;
    endtask

    task automatic test_small_range();
        s_rst = 0; s_en = 1; s_mode = 2'b10;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++; if (d_cnt !== 1'(k % 2)) begin errors++; $display("FAIL m1_cnt k=%0d got=%0d exp=%0d", k, d_cnt, k % 2); end
            checks++; if (d_dir !== 1'(k % 2)) begin errors++; $display("FAIL m1_dir k=%0d got=%b exp=%0d", k, d_dir, k % 2); end
            checks++; if (d_tc !== (k >= 2)) begin errors++; $display("FAIL m1_tc k=%0d got=%b exp=%b", k, d_tc, (k >= 2)); end
            checks++; if (e_cnt !== 2'd0) begin errors++; $display("FAIL m0_cnt k=%0d got=%0d exp=0", k, e_cnt); end
            checks++; if (e_tc !== 1'b1) begin errors++; $display("FAIL m0_tc k=%0d got=%b exp=1", k, e_tc); end
            checks++; if (e_dir !== 1'b1) begin errors++; $display("FAIL m0_dir k=%0d got=%b exp=1", k, e_dir); end
        end
        s_mode = 2'b01;
        @(negedge clk);
        checks++; if (d_cnt !== 1'b1) begin errors++; $display("FAIL m1_down_cnt got=%0d exp=1", d_cnt); end
        checks++; if (d_tc !== 1'b1) begin errors++; $display("FAIL m1_down_tc got=%b exp=1", d_tc); end
        checks++; if (e_cnt !== 2'd0) begin errors++; $display("FAIL m0_down_cnt got=%0d exp=0", e_cnt); end
        checks++; if (e_tc !== 1'b1) begin errors++; $display("FAIL m0_down_tc got=%b exp=1", e_tc); end
        s_mode = 2'b10;
        @(negedge clk);
        checks++; if (d_cnt !== 1'b0) begin errors++; $display("FAIL m1_rebounce_cnt got=%0d exp=0", d_cnt); end
        checks++; if (d_tc !== 1'b0) begin errors++; $display("FAIL m1_rebounce_tc got=%b exp=0", d_tc); end
        checks++; if (e_dir !== 1'b0) begin errors++; $display("FAIL m0_bounce_dir got=%b exp=0", e_dir); end
        checks++; if (e_tc !== 1'b1) begin errors++; $display("FAIL m0_bounce_tc got=%b exp=1", e_tc); end
        s_en = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_up_wrap();
        test_prescale();
        test_load();
        test_down_hold();
        test_bounce();
        test_reset_mid();
        test_small_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
